// File: rtl/m_cache_pkg.sv
// m_cache_pkg: shared types for the fully associative LRU cache.
// FSM state enum, age-width helper and memory-op encodings.
package m_cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB,
        S_FILL,
        S_RESP,
        S_FL_SCAN,
        S_FL_WB
    } state_t;

    localparam logic MEM_OP_WB   = 1'b1;
    localparam logic MEM_OP_FILL = 1'b0;

    function automatic int age_w(input int lines);
        return (lines > 1) ? $clog2(lines) : 1;
    endfunction

endpackage

// File: rtl/m_cache_lru_ages.sv
// m_cache_lru_ages: true-LRU age vector, 0 = most recently used.
// Ages stay a permutation of 0..LINES-1; reset gives age[i] = i.
module m_cache_lru_ages #(
    parameter int LINES = 4,
    parameter int AGE_W = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        touch_en,
    input  logic [AGE_W-1:0]            touch_idx,
    output logic [LINES-1:0][AGE_W-1:0] ages,
    output logic [AGE_W-1:0]            oldest_idx
);

    // touched line becomes youngest, younger lines age by one
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LINES; i++)
                ages[i] <= AGE_W'(i);
        end else if (touch_en) begin
            for (int i = 0; i < LINES; i++) begin
                if (AGE_W'(i) == touch_idx)
                    ages[i] <= '0;
                else if (ages[i] < ages[touch_idx])
                    ages[i] <= ages[i] + AGE_W'(1);
            end
        end
    end

    // locate the line holding the maximum age
    always_comb begin
        oldest_idx = '0;
        for (int i = 0; i < LINES; i++)
            if (ages[i] == AGE_W'(LINES - 1))
                oldest_idx = AGE_W'(i);
    end

endmodule

// File: rtl/m_cache_lru.sv
// m_cache_lru: write-back, write-allocate, true-LRU cache.
// Optional hit/miss counters behind M_CACHE_STATS_EN.
module m_cache_lru
    import m_cache_pkg::*;
#(
    parameter int LINES  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wren,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_hit,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              mem_req,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef M_CACHE_STATS_EN
   ,output logic [CNT_W-1:0]  stat_hits,
    output logic [CNT_W-1:0]  stat_misses
`endif
);

    localparam int IDX_W = age_w(LINES);

    state_t state, state_n;

    logic [ADDR_W-1:0] tag  [LINES];
    logic [DATA_W-1:0] data [LINES];
    logic [LINES-1:0]  valid, dirty;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata;
    logic              r_wren, r_hit;
    logic [IDX_W-1:0]  r_idx;
    logic              flush_pend;

    logic              hit, inv_found, fl_found, vic_wb;
    logic [IDX_W-1:0]  hit_idx, inv_idx, fl_idx, victim;
    logic [IDX_W-1:0]  oldest_idx;
    logic [LINES-1:0][IDX_W-1:0] ages;
    logic              unused_ages;
    logic              mem_go;

    assign req_ready   = (state == S_IDLE);
    assign mem_go      = mem_req && mem_ack;
    assign unused_ages = ^ages;

    m_cache_lru_ages #(
        .LINES (LINES),
        .AGE_W (IDX_W)
    ) u_ages (
        .clock      (clock),
        .reset      (reset),
        .touch_en   (state == S_RESP),
        .touch_idx  (r_idx),
        .ages       (ages),
        .oldest_idx (oldest_idx)
    );

    // tag compare, victim choice and lowest dirty line for flush
    always_comb begin
        hit       = 1'b0;
        hit_idx   = '0;
        inv_found = 1'b0;
        inv_idx   = '0;
        fl_found  = 1'b0;
        fl_idx    = '0;
        for (int i = LINES - 1; i >= 0; i--) begin
            if (valid[i] && tag[i] == r_addr) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!valid[i]) begin
                inv_found = 1'b1;
                inv_idx   = IDX_W'(i);
            end
            if (valid[i] && dirty[i]) begin
                fl_found = 1'b1;
                fl_idx   = IDX_W'(i);
            end
        end
        victim = inv_found ? inv_idx : oldest_idx;
        vic_wb = valid[victim] && dirty[victim];
    end

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // next-state decode
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:
                if (flush_req)
                    state_n = S_FL_SCAN;
                else if (req_valid)
                    state_n = S_LOOKUP;
            S_LOOKUP:
                if (hit)
                    state_n = S_RESP;
                else if (vic_wb)
                    state_n = S_WB;
                else if (!r_wren)
                    state_n = S_FILL;
                else
                    state_n = S_RESP;
            S_WB:
                if (mem_go)
                    state_n = r_wren ? S_RESP : S_FILL;
            S_FILL:
                if (mem_go)
                    state_n = S_RESP;
            S_RESP:
                state_n = S_IDLE;
            S_FL_SCAN:
                state_n = fl_found ? S_FL_WB : S_IDLE;
            S_FL_WB:
                if (mem_go)
                    state_n = S_FL_SCAN;
            default:
                state_n = S_IDLE;
        endcase
    end

    // line array, request latch, responses and memory port
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LINES; i++) begin
                tag[i]  <= '0;
                data[i] <= '0;
            end
            valid      <= '0;
            dirty      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_wren     <= 1'b0;
            r_hit      <= 1'b0;
            r_idx      <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_hit   <= 1'b0;
            flush_pend <= 1'b0;
            flush_done <= 1'b0;
            mem_req    <= 1'b0;
            mem_wren   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            resp_valid <= (state == S_RESP);
            flush_pend <= (state == S_FL_SCAN) && !fl_found;
            flush_done <= flush_pend;
            unique case (state)
                S_IDLE:
                    if (!flush_req && req_valid) begin
                        r_addr  <= req_addr;
                        r_wdata <= req_data;
                        r_wren  <= req_wren;
                    end
                S_LOOKUP: begin
                    r_hit <= hit;
                    r_idx <= hit ? hit_idx : victim;
                    if (hit) begin
                        if (r_wren) begin
                            data[hit_idx]  <= r_wdata;
                            dirty[hit_idx] <= 1'b1;
                            r_rdata        <= r_wdata;
                        end else begin
                            r_rdata <= data[hit_idx];
                        end
                    end else if (r_wren && !vic_wb) begin
                        tag[victim]   <= r_addr;
                        data[victim]  <= r_wdata;
                        valid[victim] <= 1'b1;
                        dirty[victim] <= 1'b1;
                        r_rdata       <= r_wdata;
                    end
                end
                S_WB:
                    if (mem_go && r_wren) begin
                        tag[r_idx]   <= r_addr;
                        data[r_idx]  <= r_wdata;
                        valid[r_idx] <= 1'b1;
                        dirty[r_idx] <= 1'b1;
                        r_rdata      <= r_wdata;
                    end
                S_FILL:
                    if (mem_go) begin
                        tag[r_idx]   <= r_addr;
                        data[r_idx]  <= mem_rdata;
                        valid[r_idx] <= 1'b1;
                        dirty[r_idx] <= 1'b0;
                        r_rdata      <= mem_rdata;
                    end
                S_RESP: begin
                    resp_data <= r_rdata;
                    resp_hit  <= r_hit;
                end
                S_FL_SCAN:
                    r_idx <= fl_idx;
                S_FL_WB:
                    if (mem_go)
                        dirty[r_idx] <= 1'b0;
                default: ;
            endcase
            unique case (state_n)
                S_WB:
                    if (state == S_LOOKUP) begin
                        mem_req   <= 1'b1;
                        mem_wren  <= MEM_OP_WB;
                        mem_addr  <= tag[victim];
                        mem_wdata <= data[victim];
                    end
                S_FILL:
                    if (state != S_FILL) begin
                        mem_req  <= 1'b1;
                        mem_wren <= MEM_OP_FILL;
                        mem_addr <= r_addr;
                    end
                S_FL_WB:
                    if (state == S_FL_SCAN) begin
                        mem_req   <= 1'b1;
                        mem_wren  <= MEM_OP_WB;
                        mem_addr  <= tag[fl_idx];
                        mem_wdata <= data[fl_idx];
                    end
                default:
                    mem_req <= 1'b0;
            endcase
        end
    end

`ifdef M_CACHE_STATS_EN
    // saturating hit/miss counters, stepped once per response
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (state == S_RESP) begin
            if (r_hit) begin
                if (stat_hits != '1)
                    stat_hits <= stat_hits + CNT_W'(1);
            end else begin
                if (stat_misses != '1)
                    stat_misses <= stat_misses + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_m_cache_lru.sv
// tb_m_cache_lru: randomized self-checking bench for m_cache_lru.
// Reference model: line table plus an MRU-first queue of indices.
module tb_m_cache_lru;

    localparam int LINES = 4;
    localparam int CW    = 16;

    logic       clock;
    logic       reset;
    logic       req_valid, req_ready, req_wren;
    logic [7:0] req_addr, req_data;
    logic       resp_valid, resp_hit;
    logic [7:0] resp_data;
    logic       flush_req, flush_done;
    logic       mem_req, mem_wren, mem_ack;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
`ifdef M_CACHE_STATS_EN
    logic [CW-1:0] stat_hits, stat_misses;
    int exp_hits, exp_misses;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  mem [256];
    bit          mv [LINES];
    bit          md [LINES];
    logic [7:0]  mt [LINES];
    logic [7:0]  mdat [LINES];
    int          lru[$];
    logic [16:0] mlog[$];
    logic [16:0] exp_ops[$];
    bit          hold_mem;
    int          wait_cnt;

    m_cache_lru #(
        .LINES(LINES), .ADDR_W(8), .DATA_W(8), .CNT_W(CW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wren   (req_wren),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_hit   (resp_hit),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .mem_req    (mem_req),
        .mem_wren   (mem_wren),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
`ifdef M_CACHE_STATS_EN
       ,.stat_hits  (stat_hits),
        .stat_misses(stat_misses)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // memory responder with random latency, logs every transaction
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        wait_cnt  = 0;
        forever begin
            @(negedge clock);
            mem_ack = 1'b0;
            if (reset) begin
                wait_cnt = 0;
            end else if (mem_req && !hold_mem) begin
                if (wait_cnt == 0) begin
                    mem_ack = 1'b1;
                    mlog.push_back({mem_wren, mem_addr,
                                    mem_wren ? mem_wdata : 8'h00});
                    if (mem_wren)
                        mem[mem_addr] = mem_wdata;
                    else
                        mem_rdata = mem[mem_addr];
                    wait_cnt = $urandom_range(0, 3);
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    function automatic void model_reset();
        for (int i = 0; i < LINES; i++) begin
            mv[i] = 0; md[i] = 0; mt[i] = 0; mdat[i] = 0;
        end
        lru.delete();
        for (int i = 0; i < LINES; i++) lru.push_back(i);
`ifdef M_CACHE_STATS_EN
        exp_hits = 0; exp_misses = 0;
`endif
    endfunction

    function automatic void touch(int k);
        int pos;
        pos = 0;
        for (int j = 0; j < lru.size(); j++)
            if (lru[j] == k) pos = j;
        lru.delete(pos);
        lru.push_front(k);
    endfunction

    function automatic void model_req(input bit wr, input logic [7:0] a,
                                      input logic [7:0] d, output bit hit,
                                      output logic [7:0] dat);
        int k;
        k = -1;
        hit = 0;
        exp_ops.delete();
        for (int i = 0; i < LINES; i++)
            if (mv[i] && mt[i] == a) begin k = i; hit = 1; end
        if (!hit) begin
            for (int i = LINES - 1; i >= 0; i--)
                if (!mv[i]) k = i;
            if (k < 0) k = lru[lru.size() - 1];
            if (mv[k] && md[k]) exp_ops.push_back({1'b1, mt[k], mdat[k]});
            if (!wr) exp_ops.push_back({1'b0, a, 8'h00});
            mt[k] = a; mv[k] = 1; md[k] = wr;
            mdat[k] = wr ? d : mem[a];
        end else if (wr) begin
            mdat[k] = d; md[k] = 1;
        end
        dat = mdat[k];
        touch(k);
`ifdef M_CACHE_STATS_EN
        if (hit) exp_hits++; else exp_misses++;
`endif
    endfunction

    task automatic apply_reset();
        @(negedge clock);
        reset = 1; req_valid = 0; req_wren = 0; req_addr = 0;
        req_data = 0; flush_req = 0;
        repeat (2) @(negedge clock);
        reset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1; req_valid = 0; req_wren = 0; req_addr = 0;
        req_data = 0; flush_req = 0; hold_mem = 0;
        repeat (3) @(negedge clock);
        n_chk++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready got %b want 1", req_ready);
        end
        n_chk++;
        if ({resp_valid, resp_hit, flush_done, mem_req, mem_wren} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want 0",
                     {resp_valid, resp_hit, flush_done, mem_req, mem_wren});
        end
        n_chk++;
        if ({resp_data, mem_addr, mem_wdata} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_data got %h want 0",
                     {resp_data, mem_addr, mem_wdata});
        end
        reset = 0;
        model_reset();
    endtask

    task automatic test_access(input bit wr, input logic [7:0] a,
                               input logic [7:0] d, output bit hit,
                               output logic [7:0] dat, output int lat);
        bit eh;
        logic [7:0] ed;
        model_req(wr, a, d, eh, ed);
        @(negedge clock);
        mlog.delete();
        req_valid = 1; req_wren = wr; req_addr = a; req_data = d;
        @(posedge clock); #1;
        req_valid = 0;
        lat = 0;
        while (!resp_valid && lat < 300) begin
            @(posedge clock); #1; lat++;
        end
        hit = resp_hit;
        dat = resp_data;
        n_chk++;
        if (resp_valid !== 1'b1) begin
            n_fail++; $display("FAIL access_timeout addr %h got no resp", a);
        end
        n_chk++;
        if (hit !== eh) begin
            n_fail++; $display("FAIL access_hit addr %h got %b want %b", a, hit, eh);
        end
        n_chk++;
        if (dat !== ed) begin
            n_fail++; $display("FAIL access_data addr %h got %h want %h", a, dat, ed);
        end
        n_chk++;
        if (mlog.size() != exp_ops.size()) begin
            n_fail++;
            $display("FAIL access_memops addr %h got %0d ops want %0d",
                     a, mlog.size(), exp_ops.size());
        end else begin
            foreach (exp_ops[j]) begin
                n_chk++;
                if (mlog[j] !== exp_ops[j]) begin
                    n_fail++;
                    $display("FAIL access_memop%0d got %h want %h",
                             j, mlog[j], exp_ops[j]);
                end
            end
        end
        if (exp_ops.size() == 0) begin
            n_chk++;
            if (lat != 2) begin
                n_fail++; $display("FAIL access_latency got %0d want 2", lat);
            end
        end
`ifdef M_CACHE_STATS_EN
        n_chk++;
        if (stat_hits !== CW'(exp_hits) || stat_misses !== CW'(exp_misses)) begin
            n_fail++;
            $display("FAIL stats got %0d/%0d want %0d/%0d",
                     stat_hits, stat_misses, exp_hits, exp_misses);
        end
`endif
        @(posedge clock); #1;
        n_chk++;
        if (resp_valid !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL resp_pulse got valid %b mem_req %b want 0 0",
                     resp_valid, mem_req);
        end
    endtask

    task automatic test_read_miss_hit();
        bit h; logic [7:0] dt; int lat;
        mem[8'h05] = 8'hA1;
        test_access(0, 8'h05, 8'h00, h, dt, lat);
        n_chk++;
        if (h !== 1'b0 || dt !== 8'hA1) begin
            n_fail++; $display("FAIL first_read got %b/%h want 0/a1", h, dt);
        end
        test_access(0, 8'h05, 8'h00, h, dt, lat);
        n_chk++;
        if (h !== 1'b1 || dt !== 8'hA1 || lat != 2) begin
            n_fail++;
            $display("FAIL read_hit got %b/%h/%0d want 1/a1/2", h, dt, lat);
        end
    endtask

    task automatic test_lru_writeback();
        bit h; logic [7:0] dt; int lat;
        test_access(0, 8'h03, 8'h00, h, dt, lat);
        test_access(0, 8'h07, 8'h00, h, dt, lat);
        test_access(0, 8'h0B, 8'h00, h, dt, lat);
        test_access(1, 8'h03, 8'h7E, h, dt, lat);
        n_chk++;
        if (h !== 1'b1 || dt !== 8'h7E) begin
            n_fail++; $display("FAIL write_hit got %b/%h want 1/7e", h, dt);
        end
        test_access(0, 8'h05, 8'h00, h, dt, lat);
        test_access(0, 8'h07, 8'h00, h, dt, lat);
        test_access(0, 8'h0B, 8'h00, h, dt, lat);
        test_access(0, 8'h09, 8'h00, h, dt, lat);
        n_chk++;
        if (mlog.size() != 2 || mlog[0] !== 17'h1037E
            || mlog[1] !== 17'h00900) begin
            n_fail++; $display("FAIL lru_evict got %0d ops want wb 03/7e then fill 09",
                               mlog.size());
        end
    endtask

    task automatic test_write_miss();
        bit h; logic [7:0] dt; int lat;
        apply_reset();
        test_access(1, 8'h03, 8'h7E, h, dt, lat);
        test_access(1, 8'h20, 8'h11, h, dt, lat);
        n_chk++;
        if (h !== 1'b0 || dt !== 8'h11 || lat != 2 || mlog.size() != 0) begin
            n_fail++;
            $display("FAIL write_miss got %b/%h/%0d/%0d want 0/11/2/0",
                     h, dt, lat, mlog.size());
        end
    endtask

    task automatic test_flush_with_req();
        bit eh, acc, rh;
        logic [7:0] ed, rd;
        logic [16:0] fl_ops[$];
        int done_at, resp_at, n_done;
        for (int i = 0; i < LINES; i++)
            if (mv[i] && md[i]) begin
                fl_ops.push_back({1'b1, mt[i], mdat[i]});
                md[i] = 0;
            end
        model_req(0, 8'h20, 8'h00, eh, ed);
        @(negedge clock);
        mlog.delete();
        flush_req = 1; req_valid = 1; req_wren = 0; req_addr = 8'h20;
        @(posedge clock); #1;
        flush_req = 0;
        done_at = -1; resp_at = -1; n_done = 0; rh = 0; rd = 0;
        for (int cyc = 1; cyc < 400 && resp_at < 0; cyc++) begin
            @(negedge clock);
            acc = req_ready && req_valid;
            @(posedge clock); #1;
            if (acc) req_valid = 0;
            if (flush_done) begin done_at = cyc; n_done++; end
            if (resp_valid) begin resp_at = cyc; rh = resp_hit; rd = resp_data; end
        end
        req_valid = 0;
        n_chk++;
        if (done_at < 0 || n_done != 1) begin
            n_fail++; $display("FAIL flush_done got %0d pulses want 1", n_done);
        end
        n_chk++;
        if (resp_at <= done_at) begin
            n_fail++;
            $display("FAIL flush_priority got resp %0d done %0d want resp later",
                     resp_at, done_at);
        end
        n_chk++;
        if (mlog.size() != fl_ops.size() || fl_ops.size() != 2) begin
            n_fail++;
            $display("FAIL flush_count got %0d want %0d", mlog.size(), fl_ops.size());
        end else begin
            foreach (fl_ops[j]) begin
                n_chk++;
                if (mlog[j] !== fl_ops[j]) begin
                    n_fail++;
                    $display("FAIL flush_wb%0d got %h want %h", j, mlog[j], fl_ops[j]);
                end
            end
        end
        n_chk++;
        if (rh !== eh || rd !== ed) begin
            n_fail++;
            $display("FAIL flush_req_resp got %b/%h want %b/%h", rh, rd, eh, ed);
        end
        @(negedge clock);
    endtask

    task automatic test_flush_empty();
        int lat;
        @(negedge clock);
        mlog.delete();
        flush_req = 1;
        @(posedge clock); #1;
        flush_req = 0;
        lat = 0;
        while (!flush_done && lat < 100) begin
            @(posedge clock); #1; lat++;
        end
        n_chk++;
        if (lat != 2 || mlog.size() != 0) begin
            n_fail++;
            $display("FAIL flush_empty got lat %0d ops %0d want 2 0",
                     lat, mlog.size());
        end
        @(posedge clock); #1;
        n_chk++;
        if (flush_done !== 1'b0) begin
            n_fail++; $display("FAIL flush_pulse got %b want 0", flush_done);
        end
    endtask

    task automatic test_reset_mid_fill();
        bit h; logic [7:0] dt; int lat, cyc;
        test_access(1, 8'h40, 8'h55, h, dt, lat);
        hold_mem = 1;
        @(negedge clock);
        req_valid = 1; req_wren = 0; req_addr = 8'h41;
        @(posedge clock); #1;
        req_valid = 0;
        cyc = 0;
        while (!mem_req && cyc < 20) begin
            @(posedge clock); #1; cyc++;
        end
        n_chk++;
        if (mem_req !== 1'b1 || mem_wren !== 1'b0 || mem_addr !== 8'h41) begin
            n_fail++;
            $display("FAIL fill_req got %b/%b/%h want 1/0/41",
                     mem_req, mem_wren, mem_addr);
        end
        @(negedge clock);
        reset = 1;
        #1;
        n_chk++;
        if (mem_req !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got %b/%b/%b want 0/1/0",
                     mem_req, req_ready, resp_valid);
        end
`ifdef M_CACHE_STATS_EN
        n_chk++;
        if (stat_hits !== '0 || stat_misses !== '0) begin
            n_fail++;
            $display("FAIL reset_stats got %0d/%0d want 0/0", stat_hits, stat_misses);
        end
`endif
        @(negedge clock);
        reset = 0;
        hold_mem = 0;
        model_reset();
        mem[8'h40] = 8'h3C;
        test_access(0, 8'h40, 8'h00, h, dt, lat);
        n_chk++;
        if (h !== 1'b0 || dt !== 8'h3C) begin
            n_fail++; $display("FAIL dirty_lost got %b/%h want 0/3c", h, dt);
        end
    endtask

    task automatic test_random();
        bit h; logic [7:0] dt; int lat;
        for (int n = 0; n < 80; n++)
            test_access(1'($urandom_range(0, 1)), 8'($urandom_range(0, 11)),
                        8'($urandom), h, dt, lat);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        test_reset();
        test_read_miss_hit();
        test_lru_writeback();
        test_write_miss();
        test_flush_with_req();
        test_flush_empty();
        test_reset_mid_fill();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
